// File: rtl/start_color_encoder.sv
// Nearest-colour palette encoder: maps a 12-bit RGB pixel to one of ten fixed
// palette entries (index 1..10) by squared distance, or to index 0 when transparent.
module start_color_encoder #(
    parameter bit          KEY_EN  = 1'b1,
    parameter logic [11:0] KEY_RGB = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_rgb,
    input  logic        in_transparent,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_index,
    output logic [9:0]  out_dist
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_rgb;
    logic [3:0]  r_k;
    logic [9:0]  r_best_dist;
    logic [3:0]  r_best_idx;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [3:0]  r_out_index;
    logic [9:0]  r_out_dist;

    logic [11:0] w_pal;
    logic [3:0]  w_diff [3];
    logic [7:0]  w_sq   [3];
    logic [9:0]  w_dist;
    logic        w_better;
    logic        w_accept;
    logic        w_key_hit;

    // Candidate colour for the entry currently being evaluated.
    always_comb begin
        w_pal = 12'h000;
        case (r_k)
            4'd1:    w_pal = 12'hD42;
            4'd2:    w_pal = 12'h921;
            4'd3:    w_pal = 12'hFF9;
            4'd4:    w_pal = 12'h210;
            4'd5:    w_pal = 12'h778;
            4'd6:    w_pal = 12'h6B4;
            4'd7:    w_pal = 12'hDD0;
            4'd8:    w_pal = 12'hFFF;
            4'd9:    w_pal = 12'h0F0;
            4'd10:   w_pal = 12'hBBB;
            default: w_pal = 12'h000;
        endcase
    end

    // Per-channel absolute difference and square; channel 0 is blue, 2 is red.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [3:0] w_a;
            logic [3:0] w_b;
            assign w_a        = r_rgb[gi*4 +: 4];
            assign w_b        = w_pal[gi*4 +: 4];
            assign w_diff[gi] = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
            assign w_sq[gi]   = 8'(w_diff[gi]) * 8'(w_diff[gi]);
        end
    endgenerate

    // Max 3*225 = 675, so the 10-bit sum cannot overflow.
    assign w_dist    = 10'(w_sq[0]) + 10'(w_sq[1]) + 10'(w_sq[2]);
    assign w_better  = (w_dist < r_best_dist);
    assign w_accept  = in_valid && r_in_ready;
    assign w_key_hit = KEY_EN && (in_rgb == KEY_RGB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rgb       <= 12'h000;
            r_k         <= 4'd0;
            r_best_dist <= 10'd0;
            r_best_idx  <= 4'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_index <= 4'd0;
            r_out_dist  <= 10'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rgb      <= in_rgb;
                        r_in_ready <= 1'b0;
                        if (in_transparent || w_key_hit) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_out_index <= 4'd0;
                            r_out_dist  <= 10'd0;
                        end else begin
                            r_state     <= SEARCH;
                            r_k         <= 4'd1;
                            r_best_dist <= 10'h3FF;
                            r_best_idx  <= 4'd1;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                SEARCH: begin
                    // Strict less-than keeps the lowest index on ties.
                    if (w_better) begin
                        r_best_dist <= w_dist;
                        r_best_idx  <= r_k;
                    end
                    if (r_k == 4'd10) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out_index <= w_better ? r_k : r_best_idx;
                        r_out_dist  <= w_better ? w_dist : r_best_dist;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_dist  = r_out_dist;

endmodule

// File: tb/tb_start_color_encoder.sv
// Directed self-checking bench for start_color_encoder: palette matches, ties,
// transparency/key, back-pressure hold and mid-search reset.
module tb_start_color_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_rgb;
    logic        in_transparent;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic [9:0]  out_dist;

    int n_checks = 0;
    int n_errors = 0;

    start_color_encoder #(
        .KEY_EN  (1'b1),
        .KEY_RGB (12'hF0F)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rgb         (in_rgb),
        .in_transparent (in_transparent),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_index      (out_index),
        .out_dist       (out_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one pixel for a single accepting edge, then scramble in_rgb.
    task automatic offer(input logic [11:0] rgb, input logic tr);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid       = 1'b1;
        in_rgb         = rgb;
        in_transparent = tr;
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        in_rgb         = ~rgb;
        in_transparent = 1'b0;
    endtask

    // Count negedges after acceptance until out_valid, bounded.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic pixel(input string tag, input logic [11:0] rgb, input logic tr,
                         input int exp_lat, input logic [3:0] exp_idx, input logic [9:0] exp_dist);
        offer(rgb, tr);
        wait_result(tag, exp_lat);
        check({tag, "_index"}, 32'(out_index), 32'(exp_idx));
        check({tag, "_dist"}, 32'(out_dist), 32'(exp_dist));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        $display("pixel %s rgb=%03h tr=%0b -> index=%0d dist=%0d", tag, rgb, tr, exp_idx, exp_dist);
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_rgb         = 12'h000;
        in_transparent = 1'b0;
        out_ready      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_dist", 32'(out_dist), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        pixel("exact_d42", 12'hD42, 1'b0, 11, 4'd1, 10'd0);
        pixel("black",     12'h000, 1'b0, 11, 4'd4, 10'd5);
        pixel("tie_ffc",   12'hFFC, 1'b0, 11, 4'd3, 10'd9);
        pixel("red_700",   12'h700, 1'b0, 11, 4'd2, 10'd9);
        pixel("transp",    12'hFFF, 1'b1, 1,  4'd0, 10'd0);
        pixel("key_f0f",   12'hF0F, 1'b0, 1,  4'd0, 10'd0);

        // Back-pressure: result must hold while in_valid pulses are ignored.
        out_ready = 1'b0;
        offer(12'h0F0, 1'b0);
        wait_result("hold", 11);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_rgb   = 12'h123;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_index", 32'(out_index), 32'd9);
            check("hold_dist", 32'(out_dist), 32'd0);
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_ready", 32'(in_ready), 32'd1);
        $display("pixel hold rgb=0f0 held 5 cycles -> index=9 dist=0");

        // Reset during search: outputs clear asynchronously, no result emitted.
        offer(12'h123, 1'b0);
        repeat (5) @(negedge clk);
        check("pre_reset_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_index", 32'(out_index), 32'd0);
        check("async_rst_dist", 32'(out_dist), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("in_rst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", 32'(in_ready), 32'd1);
        $display("reset during search: outputs cleared, pixel abandoned");
        pixel("after_rst_bbb", 12'hBBB, 1'b0, 11, 4'd10, 10'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/start_color_encoder.md
START_COLOR_ENCODER -- requirements
Module: start_color_encoder

Interface
REQ-001 SHALL have parameter: KEY_EN, 1, when 1 an input pixel equal to KEY_RGB maps to transparent index 0.
REQ-002 SHALL have parameter: KEY_RGB, 12'hF0F, 12-bit colour key treated as transparent.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  pixel offered.
REQ-006 SHALL have port: in_ready  output  1  encoder can accept a pixel.
REQ-007 SHALL have port: in_rgb  input  12  pixel {R[11:8],G[7:4],B[3:0]}.
REQ-008 SHALL have port: in_transparent  input  1  pixel is transparent, force index 0.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: out_index  output  4  palette index, 0..10.
REQ-012 SHALL have port: out_dist  output  10  squared RGB distance of chosen entry, unsigned.

Function
REQ-013 SHALL hold a fixed palette, index 1..10: D42, 921, FF9, 210, 778, 6B4, DD0, FFF, 0F0, BBB. Index 0 is transparent and is never searched.
REQ-014 SHALL implement FSM states IDLE, SEARCH, DONE. in_ready=1 only in IDLE.
REQ-015 SHALL capture in_rgb/in_transparent on the edge where in_valid&in_ready; all later in_rgb changes are ignored until the next IDLE.
REQ-016 SHALL go IDLE->DONE on capture if in_transparent=1 or (KEY_EN=1 and in_rgb==KEY_RGB), with out_index=0 and out_dist=0; otherwise IDLE->SEARCH with k=1, best_dist=10'h3FF, best_idx=1.
REQ-017 SHALL in SEARCH evaluate exactly one candidate k per cycle: dist=(dR)^2+(dG)^2+(dB)^2, per-channel |diff| 4 bits, square 8 bits, sum 10 bits (max 675, no overflow).
REQ-018 SHALL update best on strict dist<best_dist only, so ties resolve to the lowest index.
REQ-019 SHALL evaluate k=1..10 with no early exit and leave SEARCH after k=10, giving fixed latency: out_valid rises 11 cycles after the acceptance edge (non-transparent) and 1 cycle after it (transparent/key).
REQ-020 SHALL in DONE assert out_valid and hold out_index/out_dist stable until out_valid&out_ready; then go to IDLE, with in_ready=1 in the next cycle.
REQ-021 SHALL ignore in_valid in SEARCH and DONE; no pixel is captured or lost silently, because in_ready=0 there.
REQ-022 SHALL update out_index/out_dist only on entry to DONE; they remain at their last value in IDLE/SEARCH, and out_valid=0 there.
REQ-023 SHALL give one pixel per 12 cycles at best (non-transparent, out_ready held 1).

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, in_ready=0, out_valid=0, out_index=0, out_dist=0, k=0, best_dist=0, best_idx=0; asynchronous assertion.
REQ-025 SHALL assert in_ready in the first cycle after rst_n deasserts.
REQ-026 SHALL abandon any pixel in SEARCH or DONE when reset asserts mid-operation; no result is emitted for it.

Verification
REQ-027 SHALL test this case: in_rgb=D42, out_ready=1 -> out_index=1, out_dist=0, out_valid 11 cycles after acceptance for exactly 1 cycle.
REQ-028 SHALL test this case: in_rgb=000 -> out_index=4 (210), out_dist=5.
REQ-029 SHALL test this case: in_rgb=FFC (tie FF9/FFF, dist 9 each) -> out_index=3, out_dist=9.
REQ-030 SHALL test this case: in_transparent=1 with in_rgb=FFF, then a second pixel in_rgb=F0F with KEY_EN=1 -> both give out_index=0, out_dist=0, 1 cycle after acceptance.
REQ-031 SHALL test this case: in_rgb=0F0, out_ready=0 for 5 cycles after out_valid -> out_valid=1, out_index=9 held, in_ready=0, in_valid pulses ignored; out_ready=1 -> handshake, in_ready=1 next cycle.
REQ-032 SHALL test this case: rst_n low during SEARCH cycle 5 -> all outputs 0 at once; after release in_ready=1, next pixel BBB -> out_index=10, out_dist=0.
